// File: rtl/parity_engine.sv
// parity_engine
//   Parity generator for the UART TX path plus parity checker for the RX path.
//   TX: on each capture (data_valid & ~busy) the data word, enable and parity
//   type are shadowed, and par_bit is produced from that shadowed state, so
//   configuration changes between captures never disturb the frame in flight.
//   RX: each chk_valid strobe compares rx_par_bit with the expected parity of
//   rx_data under the live par_en/par_typ. It drives a one-cycle par_err
//   pulse, a sticky err_flag and a saturating err_cnt.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   P_DATA            TX parallel data word (DATA_WIDTH)
//   data_valid, busy  capture qualifier: capture when data_valid=1 and busy=0
//   par_en, par_typ   parity enable; type 00 even, 01 odd, 10 mark, 11 space
//   par_bit           TX parity bit of the last captured word (registered)
//   rx_data           received data word (DATA_WIDTH)
//   rx_par_bit        received parity bit
//   chk_valid         one-cycle strobe qualifying rx_data/rx_par_bit
//   err_clr           clears err_flag and err_cnt (same-cycle error still counts)
//   par_err           one-cycle parity-error pulse (registered)
//   err_flag          sticky parity-error flag (registered)
//   err_cnt           saturating parity-error count (ERR_CNT_WIDTH, registered)
module parity_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    P_DATA,
  input  logic                     data_valid,
  input  logic                     busy,
  input  logic                     par_en,
  input  logic [1:0]               par_typ,
  output logic                     par_bit,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_par_bit,
  input  logic                     chk_valid,
  input  logic                     err_clr,
  output logic                     par_err,
  output logic                     err_flag,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX  = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ZERO = {ERR_CNT_WIDTH{1'b0}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE  = ERR_CNT_WIDTH'(1);

  // Parity of a word under one of the four parity types.
  function automatic logic par_fn(input logic [DATA_WIDTH-1:0] d,
                                  input logic [1:0]            typ);
    logic p;
    case (typ)
      2'b00:   p = ^d;
      2'b01:   p = ~(^d);
      2'b10:   p = 1'b1;
      2'b11:   p = 1'b0;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  logic [DATA_WIDTH-1:0]    shadow_data_q, shadow_data_d;
  logic                     shadow_en_q,   shadow_en_d;
  logic [1:0]               shadow_typ_q,  shadow_typ_d;
  logic                     par_bit_q,     par_bit_d;
  logic                     par_err_q,     par_err_d;
  logic                     err_flag_q,    err_flag_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q,     err_cnt_d;

  logic                     capture_s;
  logic                     mismatch_s;
  logic                     flag_base_s;
  logic [ERR_CNT_WIDTH-1:0] cnt_base_s;

  // TX shadow capture and parity bit next-state.
  always_comb begin
    capture_s     = data_valid & ~busy;
    shadow_data_d = shadow_data_q;
    shadow_en_d   = shadow_en_q;
    shadow_typ_d  = shadow_typ_q;
    if (capture_s) begin
      shadow_data_d = P_DATA;
      shadow_en_d   = par_en;
      shadow_typ_d  = par_typ;
    end else begin
      shadow_data_d = shadow_data_q;
      shadow_en_d   = shadow_en_q;
      shadow_typ_d  = shadow_typ_q;
    end
    // Re-deriving the bit from the shadow every cycle yields the new parity on
    // a capture and the same value while holding; it also self-repairs a
    // disturbed par_bit flop on the next edge.
    if (shadow_en_d) begin
      par_bit_d = par_fn(shadow_data_d, shadow_typ_d);
    end else begin
      par_bit_d = 1'b0;
    end
  end

  // RX check: error pulse, sticky flag and saturating counter next-state.
  always_comb begin
    mismatch_s = chk_valid & par_en & (rx_par_bit != par_fn(rx_data, par_typ));
    par_err_d  = mismatch_s;
    // Clear is applied first so a same-cycle mismatch survives the clear.
    if (err_clr) begin
      flag_base_s = 1'b0;
      cnt_base_s  = CNT_ZERO;
    end else begin
      flag_base_s = err_flag_q;
      cnt_base_s  = err_cnt_q;
    end
    err_flag_d = flag_base_s | mismatch_s;
    if (mismatch_s && (cnt_base_s != CNT_MAX)) begin
      err_cnt_d = cnt_base_s + CNT_ONE;
    end else begin
      err_cnt_d = cnt_base_s;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data_q <= {DATA_WIDTH{1'b0}};
      shadow_en_q   <= 1'b0;
      shadow_typ_q  <= 2'b00;
      par_bit_q     <= 1'b0;
      par_err_q     <= 1'b0;
      err_flag_q    <= 1'b0;
      err_cnt_q     <= CNT_ZERO;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_en_q   <= shadow_en_d;
      shadow_typ_q  <= shadow_typ_d;
      par_bit_q     <= par_bit_d;
      par_err_q     <= par_err_d;
      err_flag_q    <= err_flag_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign par_bit  = par_bit_q;
  assign par_err  = par_err_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_parity_engine.sv
// Self-checking bench for parity_engine. Four instances share one stimulus
// bus, each seeing its own slice: u_a (8-bit data, 8-bit counter),
// u_s (8-bit data, 2-bit counter for saturation), u_1 (1-bit data) and
// u_w (32-bit data). A behavioural model (population-count parity, integer
// counters clamped to a limit) predicts every instance's outputs.
module tb_parity_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] p_data = 32'd0;
  logic        data_valid = 1'b0, busy = 1'b0, par_en = 1'b0;
  logic [1:0]  par_typ = 2'b00;
  logic [31:0] rx_data = 32'd0;
  logic        rx_par_bit = 1'b0, chk_valid = 1'b0, err_clr = 1'b0;

  logic        par_a, err_a, flag_a;  logic [7:0] cnt_a;
  logic        par_s, err_s, flag_s;  logic [1:0] cnt_s;
  logic        par_1, err_1, flag_1;  logic [7:0] cnt_1;
  logic        par_w, err_w, flag_w;  logic [7:0] cnt_w;

  logic        par_o [4];
  logic        err_o [4];
  logic        flag_o[4];
  logic [31:0] cnt_o [4];

  // Behavioural model state per instance.
  int width_m [4] = '{8, 8, 1, 32};
  int limit_m [4] = '{255, 3, 255, 255};
  bit par_m   [4];
  bit err_m   [4];
  bit flag_m  [4];
  int cnt_m   [4];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  parity_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .P_DATA(p_data[7:0]), .data_valid(data_valid), .busy(busy),
    .par_en(par_en), .par_typ(par_typ), .par_bit(par_a), .rx_data(rx_data[7:0]),
    .rx_par_bit(rx_par_bit), .chk_valid(chk_valid), .err_clr(err_clr),
    .par_err(err_a), .err_flag(flag_a), .err_cnt(cnt_a));

  parity_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u_s (
    .clk(clk), .rst(rst), .P_DATA(p_data[7:0]), .data_valid(data_valid), .busy(busy),
    .par_en(par_en), .par_typ(par_typ), .par_bit(par_s), .rx_data(rx_data[7:0]),
    .rx_par_bit(rx_par_bit), .chk_valid(chk_valid), .err_clr(err_clr),
    .par_err(err_s), .err_flag(flag_s), .err_cnt(cnt_s));

  parity_engine #(.DATA_WIDTH(1), .ERR_CNT_WIDTH(8)) u_1 (
    .clk(clk), .rst(rst), .P_DATA(p_data[0:0]), .data_valid(data_valid), .busy(busy),
    .par_en(par_en), .par_typ(par_typ), .par_bit(par_1), .rx_data(rx_data[0:0]),
    .rx_par_bit(rx_par_bit), .chk_valid(chk_valid), .err_clr(err_clr),
    .par_err(err_1), .err_flag(flag_1), .err_cnt(cnt_1));

  parity_engine #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) u_w (
    .clk(clk), .rst(rst), .P_DATA(p_data), .data_valid(data_valid), .busy(busy),
    .par_en(par_en), .par_typ(par_typ), .par_bit(par_w), .rx_data(rx_data),
    .rx_par_bit(rx_par_bit), .chk_valid(chk_valid), .err_clr(err_clr),
    .par_err(err_w), .err_flag(flag_w), .err_cnt(cnt_w));

  assign par_o[0] = par_a;  assign err_o[0] = err_a;  assign flag_o[0] = flag_a;
  assign par_o[1] = par_s;  assign err_o[1] = err_s;  assign flag_o[1] = flag_s;
  assign par_o[2] = par_1;  assign err_o[2] = err_1;  assign flag_o[2] = flag_1;
  assign par_o[3] = par_w;  assign err_o[3] = err_w;  assign flag_o[3] = flag_w;
  assign cnt_o[0] = {24'd0, cnt_a};
  assign cnt_o[1] = {30'd0, cnt_s};
  assign cnt_o[2] = {24'd0, cnt_1};
  assign cnt_o[3] = {24'd0, cnt_w};

  // Parity from a count of ones over the low w bits.
  function automatic bit ref_par(input logic [31:0] d, input int w, input logic [1:0] typ);
    int ones = 0;
    for (int i = 0; i < w; i++) if (d[i]) ones++;
    case (typ)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      par_m[k] = 1'b0; err_m[k] = 1'b0; flag_m[k] = 1'b0; cnt_m[k] = 0;
    end
  endtask

  // Advance the model with the inputs present now, then clock the DUTs.
  task automatic cycle();
    bit mis;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        par_m[k] = 1'b0; err_m[k] = 1'b0; flag_m[k] = 1'b0; cnt_m[k] = 0;
      end else begin
        if (data_valid && !busy)
          par_m[k] = par_en ? ref_par(p_data, width_m[k], par_typ) : 1'b0;
        mis = chk_valid && par_en && (rx_par_bit != ref_par(rx_data, width_m[k], par_typ));
        err_m[k] = mis;
        if (err_clr) begin flag_m[k] = 1'b0; cnt_m[k] = 0; end
        if (mis) begin
          flag_m[k] = 1'b1;
          cnt_m[k] = (cnt_m[k] + 1 > limit_m[k]) ? limit_m[k] : cnt_m[k] + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_valid = 1'b0; busy = 1'b0; chk_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    cycle();
    cycle();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({par_o[k], err_o[k], flag_o[k], cnt_o[k]} !== 35'd0)
        $display("FAIL reset k=%0d got par=%b err=%b flag=%b cnt=%0d exp all 0",
                 k, par_o[k], err_o[k], flag_o[k], cnt_o[k]);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    #6;
  endtask

  task automatic test_tx_modes();
    logic [7:0] d_t [6] = '{8'hA5, 8'h07, 8'h07, 8'h3C, 8'h3C, 8'hFF};
    logic [1:0] t_t [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic       e_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       x_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      p_data = {24'd0, d_t[i]}; par_typ = t_t[i]; par_en = e_t[i]; data_valid = 1'b1;
      cycle();
      n_checks++;
      if (par_a !== x_t[i])
        $display("FAIL tx_mode[%0d] got par_bit=%b exp=%b", i, par_a, x_t[i]);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_shadow();
    p_data = 32'h01; par_en = 1'b1; par_typ = 2'b00; data_valid = 1'b1;
    cycle();
    n_checks++;
    if (par_a !== 1'b1) $display("FAIL shadow_cap got par_bit=%b exp=1", par_a);
    else n_pass++;
    busy = 1'b1; par_typ = 2'b01; p_data = 32'h00;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (par_a !== 1'b1) $display("FAIL shadow_hold[%0d] got par_bit=%b exp=1", i, par_a);
      else n_pass++;
    end
    busy = 1'b0;
    cycle();
    n_checks++;
    if (par_a !== 1'b1) $display("FAIL shadow_recap got par_bit=%b exp=1", par_a);
    else n_pass++;
    // Back-to-back captures: parity follows each word one cycle later.
    par_typ = 2'b00;
    for (int i = 0; i < 4; i++) begin
      p_data = 32'(i);
      cycle();
      n_checks++;
      if (par_a !== par_m[0]) $display("FAIL b2b[%0d] got par_bit=%b exp=%b", i, par_a, par_m[0]);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_rx();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    rx_data = 32'hA5; rx_par_bit = 1'b1; par_en = 1'b1; par_typ = 2'b00; chk_valid = 1'b1;
    cycle();
    chk_valid = 1'b0;
    n_checks++;
    if ({err_a, flag_a, cnt_a} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL rx_mismatch got err=%b flag=%b cnt=%0d exp 1 1 1", err_a, flag_a, cnt_a);
    else n_pass++;
    cycle();
    n_checks++;
    if ({err_a, flag_a, cnt_a} !== {1'b0, 1'b1, 8'd1})
      $display("FAIL rx_pulse_end got err=%b flag=%b cnt=%0d exp 0 1 1", err_a, flag_a, cnt_a);
    else n_pass++;
    rx_par_bit = 1'b0; chk_valid = 1'b1;
    cycle();
    n_checks++;
    if ({err_a, cnt_a} !== {1'b0, 8'd1})
      $display("FAIL rx_match got err=%b cnt=%0d exp 0 1", err_a, cnt_a);
    else n_pass++;
    rx_par_bit = 1'b1; par_en = 1'b0;
    cycle();
    n_checks++;
    if ({err_a, cnt_a} !== {1'b0, 8'd1})
      $display("FAIL rx_disabled got err=%b cnt=%0d exp 0 1", err_a, cnt_a);
    else n_pass++;
    idle();
  endtask

  task automatic test_saturation();
    int exp_s [5] = '{1, 2, 3, 3, 3};
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    rx_data = 32'hA5; rx_par_bit = 1'b1; par_en = 1'b1; par_typ = 2'b00; chk_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if ({30'd0, cnt_s} !== 32'(exp_s[i]))
        $display("FAIL sat[%0d] got cnt=%0d exp=%0d", i, cnt_s, exp_s[i]);
      else n_pass++;
    end
    err_clr = 1'b1;
    cycle();
    n_checks++;
    if ({flag_s, cnt_s, cnt_a} !== {1'b1, 2'd1, 8'd1})
      $display("FAIL clr_with_err got flag=%b cnt_s=%0d cnt_a=%0d exp 1 1 1", flag_s, cnt_s, cnt_a);
    else n_pass++;
    chk_valid = 1'b0;
    cycle();
    n_checks++;
    if ({flag_s, cnt_s, flag_a, cnt_a} !== {1'b0, 2'd0, 1'b0, 8'd0})
      $display("FAIL clr_alone got flag=%b cnt=%0d exp 0 0", flag_s, cnt_s);
    else n_pass++;
    idle();
  endtask

  task automatic test_width();
    par_en = 1'b1; data_valid = 1'b1; p_data = 32'h8000_0001; par_typ = 2'b00;
    cycle();
    n_checks++;
    if ({par_w, par_1} !== 2'b01)
      $display("FAIL width_even got w32=%b w1=%b exp 0 1", par_w, par_1);
    else n_pass++;
    par_typ = 2'b01;
    cycle();
    n_checks++;
    if ({par_w, par_1} !== 2'b10)
      $display("FAIL width_odd got w32=%b w1=%b exp 1 0", par_w, par_1);
    else n_pass++;
    idle();
  endtask

  task automatic test_async_reset();
    rx_data = 32'hA5; rx_par_bit = 1'b1; par_en = 1'b1; par_typ = 2'b10;
    chk_valid = 1'b1; data_valid = 1'b1; p_data = 32'h0;
    cycle();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({par_o[k], err_o[k], flag_o[k], cnt_o[k]} !== 35'd0)
        $display("FAIL async_rst k=%0d got par=%b err=%b flag=%b cnt=%0d exp all 0",
                 k, par_o[k], err_o[k], flag_o[k], cnt_o[k]);
      else n_pass++;
    end
    cycle();
    n_checks++;
    if (par_a !== 1'b0) $display("FAIL rst_capture_lost got par_bit=%b exp=0", par_a);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    idle();
    #6;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      p_data     = $urandom;
      rx_data    = $urandom;
      data_valid = ($urandom_range(3) != 0);
      busy       = ($urandom_range(3) == 0);
      par_en     = ($urandom_range(4) != 0);
      par_typ    = 2'($urandom_range(3));
      rx_par_bit = 1'($urandom_range(1));
      chk_valid  = ($urandom_range(2) != 0);
      err_clr    = ($urandom_range(15) == 0);
      cycle();
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({par_o[k], err_o[k], flag_o[k], cnt_o[k]} !==
            {par_m[k], err_m[k], flag_m[k], 32'(cnt_m[k])})
          $display("FAIL random[%0d] k=%0d got par=%b err=%b flag=%b cnt=%0d exp par=%b err=%b flag=%b cnt=%0d",
                   n, k, par_o[k], err_o[k], flag_o[k], cnt_o[k],
                   par_m[k], err_m[k], flag_m[k], cnt_m[k]);
        else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    #2;
    test_reset();
    test_tx_modes();
    test_shadow();
    test_rx();
    test_saturation();
    test_width();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_engine.md
Name: parity_engine

Overview:
Parametrised successor to the UART parity calculator. It generates the TX parity bit for any data width, with four parity modes. Mode and data are shadowed at word capture, so a configuration change mid-frame never corrupts the frame in flight. It adds an RX-side parity checker with an error pulse, a sticky flag and a saturating error counter. It sits between the UART TX FSM/serializer and the RX deserializer/status registers.

Parameters:
DATA_WIDTH, 8, width of parallel data word (>=1)
ERR_CNT_WIDTH, 8, width of saturating parity-error counter (>=1)

Ports:
clk  input  1  system clock, all flops rising-edge
rst  input  1  asynchronous, active-high reset
P_DATA  input  DATA_WIDTH  TX parallel data
data_valid  input  1  TX data valid
busy  input  1  TX serializer busy; blocks capture when high
par_en  input  1  parity enable
par_typ  input  2  00 even, 01 odd, 10 mark (1), 11 space (0)
par_bit  output  1  TX parity bit for last captured word
rx_data  input  DATA_WIDTH  received data word
rx_par_bit  input  1  received parity bit
chk_valid  input  1  rx_data/rx_par_bit valid, one-cycle strobe
err_clr  input  1  clear err_flag and err_cnt
par_err  output  1  one-cycle parity-error pulse
err_flag  output  1  sticky parity-error flag
err_cnt  output  ERR_CNT_WIDTH  saturating parity-error count

Behaviour:
- Reset (rst=1, async): par_bit=0, par_err=0, err_flag=0, err_cnt=0. Internal shadow data, en and typ are all 0. Release is synchronous to clk.
- Parity function f(d, typ): even = XOR-reduce(d); odd = ~XOR-reduce(d); mark = 1; space = 0.
- TX capture: on a rising edge where data_valid=1 and busy=0:
  - shadow_data<=P_DATA, shadow_en<=par_en, shadow_typ<=par_typ.
  - par_bit<=par_en ? f(P_DATA, par_typ) : 0.
  - par_bit is valid the cycle after capture and holds until the next capture.
- No capture when busy=1 or data_valid=0. par_bit and shadow registers hold, even if par_en, par_typ or P_DATA change.
- Back-to-back captures (data_valid=1, busy=0 on consecutive cycles): each edge recaptures, and par_bit follows with 1-cycle latency.
- RX check on a rising edge with chk_valid=1:
  - mismatch = par_en & (rx_par_bit != f(rx_data, par_typ)). par_en and par_typ are sampled live on this cycle.
  - par_err<=mismatch. It is a one-cycle pulse and returns to 0 the next cycle unless chk_valid repeats with a mismatch.
  - If par_en=0: par_err<=0, counter and flag unchanged.
- chk_valid=0: par_err<=0.
- err_flag: set on any edge where mismatch=1. Cleared only by err_clr or rst.
- err_cnt: increments by 1 per mismatch and saturates at 2^ERR_CNT_WIDTH-1 with no wrap.
- err_clr precedence: clear is applied first, then the same-cycle error.
  - err_clr with a same-cycle mismatch gives err_cnt=1, err_flag=1.
  - err_clr alone gives 0, 0.
- TX and RX paths are independent and may be active in the same cycle.
- Reset asserted mid-operation: all outputs go to 0 immediately. A capture pending on that edge is lost.
- No combinational path from inputs to any output; all outputs are registered.

Test Plan:
- Reset, then even capture: P_DATA=8'hA5, par_en=1, par_typ=00, data_valid=1, busy=0 -> par_bit=0 next cycle. Then P_DATA=8'h07, odd -> par_bit=0; P_DATA=8'h07, even -> par_bit=1.
- Mark/space/disabled: mark -> par_bit=1; space -> par_bit=0; par_en=0 with 8'hFF odd -> par_bit=0.
- Shadowing: capture 8'h01 even (par_bit=1). Hold busy=1 and change par_typ=01, P_DATA=8'h00, data_valid=1 for 5 cycles -> par_bit stays 1. Drop busy -> recapture gives par_bit=1 (odd of 8'h00).
- RX check: rx_data=8'hA5, rx_par_bit=1, even, chk_valid 1 cycle -> par_err pulse 1 cycle, err_flag=1, err_cnt=1. Same with rx_par_bit=0 -> no pulse, count unchanged. par_en=0 with a mismatch -> no pulse.
- Saturation and clear: ERR_CNT_WIDTH=2, 5 mismatching strobes -> err_cnt 1,2,3,3,3. err_clr with a same-cycle mismatch -> err_cnt=1, err_flag=1. err_clr alone -> 0, 0.
- Async reset mid-stream and width sweep: assert rst between clk edges -> all outputs 0 without waiting for a clock edge. Rerun TX/RX checks with DATA_WIDTH=1 and 32 (32'h8000_0001 even -> 0, odd -> 1).
